branch_predictor: RTL and testbench



---
 rtl/branch_predictor.sv | 187 ++++++++++++++++++
 tb/tb_branch_predictor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Dynamic branch predictor for the fetch stage: a table of 2-bit saturating
//   counters (BHT) plus a tagged branch target buffer (BTB). Fetch presents a
//   PC and receives a registered taken/target guess one cycle later. Execute
//   feeds back resolved branches/jumps to train both tables.
//
//   Optional feature macro: BPU_GSHARE_EN
//     When defined, a GHR_W-bit global history register is XORed into the BHT
//     index for both lookup and update. The BTB always uses the plain PC index.
//
// Ports
//   clk, rst_n    core clock, asynchronous active-low reset
//   req_valid     fetch lookup request
//   req_pc        fetch PC (bits [1:0] ignored)
//   pred_valid    registered prediction valid, one cycle after req_valid
//   pred_taken    predicted taken (0 when pred_valid=0)
//   pred_target   predicted target (0 when pred_taken=0)
//   upd_valid     resolved branch/jump from execute
//   upd_pc        PC of the resolved instruction
//   upd_flush     resolution info: actual target, taken, jump, prediction,
//                 redirect (valid)
//   mispred_cnt   saturating count of resolved mispredictions
// -----------------------------------------------------------------------------
package com_pkg;
  typedef struct packed {
    logic [31:0] address;
    logic        taken;
    logic        jump;
    logic        prediction;
    logic        valid;
  } flush_t;
endpackage

module branch_predictor #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned GHR_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [31:0]      req_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  com_pkg::flush_t  upd_flush,
  output logic [15:0]      mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  // Table storage
  logic [1:0]  cnt_q     [ENTRIES];
  logic [1:0]  cnt_d     [ENTRIES];
  logic        btb_v_q   [ENTRIES];
  logic        btb_v_d   [ENTRIES];
  tag_t        btb_tag_q [ENTRIES];
  tag_t        btb_tag_d [ENTRIES];
  logic [31:0] btb_tgt_q [ENTRIES];
  logic [31:0] btb_tgt_d [ENTRIES];

  // Prediction / statistics registers
  logic        pred_valid_q,  pred_valid_d;
  logic        pred_taken_q,  pred_taken_d;
  logic [31:0] pred_target_q, pred_target_d;
  logic [15:0] mispred_q,     mispred_d;

  idx_t req_idx, upd_idx;     // BTB index (plain PC bits)
  idx_t req_bidx, upd_bidx;   // BHT index (optionally history-hashed)
  tag_t req_tag, upd_tag;

  assign req_idx = req_pc[IDX_W+1:2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign req_tag = req_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Only the index/tag fields of the PCs are meaningful.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{req_pc, upd_pc};

`ifdef BPU_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  // Both lookup and update hash with the history as it stands this cycle,
  // i.e. before any same-cycle shift.
  assign req_bidx = req_idx ^ idx_t'(ghr_q);
  assign upd_bidx = upd_idx ^ idx_t'(ghr_q);

  // Shift-and-OR form also covers GHR_W=1 without a degenerate slice.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid && !upd_flush.jump) begin
      ghr_d = (ghr_q << 1) | GHR_W'(upd_flush.taken);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  logic [GHR_W-1:0] unused_ghr;
  assign unused_ghr = '0;
  assign req_bidx   = req_idx;
  assign upd_bidx   = upd_idx;
`endif

  // Training
  always_comb begin
    cnt_d     = cnt_q;
    btb_v_d   = btb_v_q;
    btb_tag_d = btb_tag_q;
    btb_tgt_d = btb_tgt_q;
    if (upd_valid) begin
      if (upd_flush.jump) begin
        cnt_d[upd_bidx] = 2'b11;
      end else if (upd_flush.taken) begin
        if (cnt_q[upd_bidx] != 2'b11) cnt_d[upd_bidx] = cnt_q[upd_bidx] + 2'd1;
      end else begin
        if (cnt_q[upd_bidx] != 2'b00) cnt_d[upd_bidx] = cnt_q[upd_bidx] - 2'd1;
      end
      // Not-taken branches leave the BTB alone; anything else (re)allocates.
      if (upd_flush.jump || upd_flush.taken) begin
        btb_v_d[upd_idx]   = 1'b1;
        btb_tag_d[upd_idx] = upd_tag;
        btb_tgt_d[upd_idx] = upd_flush.address;
      end
    end
  end

  // Lookup reads the _q tables, so a same-cycle update is seen only by the
  // following request.
  logic look_hit;
  assign look_hit = btb_v_q[req_idx] && (btb_tag_q[req_idx] == req_tag);

  always_comb begin
    pred_valid_d  = req_valid && !upd_flush.valid;
    pred_taken_d  = pred_valid_d && look_hit && cnt_q[req_bidx][1];
    pred_target_d = pred_taken_d ? btb_tgt_q[req_idx] : '0;
  end

  always_comb begin
    mispred_d = mispred_q;
    if (upd_valid && (upd_flush.taken != upd_flush.prediction) && (mispred_q != '1)) begin
      mispred_d = mispred_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        cnt_q[i]     <= 2'b01;
        btb_v_q[i]   <= 1'b0;
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
      end
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      mispred_q     <= '0;
    end else begin
      cnt_q         <= cnt_d;
      btb_v_q       <= btb_v_d;
      btb_tag_q     <= btb_tag_d;
      btb_tgt_q     <= btb_tgt_d;
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      mispred_q     <= mispred_d;
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign mispred_cnt = mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic [31:0]      req_pc;
  logic             pred_valid;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  com_pkg::flush_t  upd_flush;
  logic [15:0]      mispred_cnt;

  int unsigned n_total;
  int unsigned n_bad;

  branch_predictor #(
    .ENTRIES (64),
    .TAG_W   (8),
    .GHR_W   (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_pc      (req_pc),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_flush   (upd_flush),
    .mispred_cnt (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    req_valid = 1'b0;
    req_pc    = '0;
    upd_valid = 1'b0;
    upd_pc    = '0;
    upd_flush = '0;
  endtask

  // One-cycle update, inputs driven and removed on falling edges.
  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                     input logic tk, input logic jmp, input logic prd);
    @(negedge clk);
    upd_valid            = 1'b1;
    upd_pc               = pc;
    upd_flush.address    = tgt;
    upd_flush.taken      = tk;
    upd_flush.jump       = jmp;
    upd_flush.prediction = prd;
    upd_flush.valid      = 1'b1;
    @(negedge clk);
    upd_valid = 1'b0;
    upd_flush = '0;
  endtask

  // Lookup and check the registered result one cycle later.
  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic exp_tk, input logic [31:0] exp_tgt);
    @(negedge clk);
    req_valid = 1'b1;
    req_pc    = pc;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, ".valid"},  {31'd0, pred_valid}, 32'd1);
    chk({tag, ".taken"},  {31'd0, pred_taken}, {31'd0, exp_tk});
    chk({tag, ".target"}, pred_target, exp_tgt);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.pred_valid", {31'd0, pred_valid}, 32'd0);
    chk("rst.pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst.pred_target", pred_target, 32'd0);
    chk("rst.mispred", {16'd0, mispred_cnt}, 32'd0);
    rst_n = 1'b1;

    // 1: cold lookup, weak NT and empty BTB
    lookup("cold", 32'h100, 1'b0, 32'h0);

    // 2: train taken twice (cnt 1->2->3), then NT twice (3->2->1)
    upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b0);
    upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b0);
    lookup("trained_t", 32'h100, 1'b1, 32'h200);
    upd(32'h100, 32'h200, 1'b0, 1'b0, 1'b1);
    upd(32'h100, 32'h200, 1'b0, 1'b0, 1'b1);
    lookup("trained_nt", 32'h100, 1'b0, 32'h0);
    chk("mispred_4", {16'd0, mispred_cnt}, 32'd4);

    // 3: five taken saturate at 3, one NT -> 2 (still taken)
    repeat (5) upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b1);
    upd(32'h100, 32'h200, 1'b0, 1'b0, 1'b1);
    lookup("sat_hi", 32'h100, 1'b1, 32'h200);
    upd(32'h40, 32'h80, 1'b1, 1'b1, 1'b1);
    lookup("jump", 32'h40, 1'b1, 32'h80);

    // 4: alias on idx 0 with different tag, then read-before-write
    lookup("alias", 32'h200, 1'b0, 32'h0);
    @(negedge clk);
    req_valid            = 1'b1;
    req_pc               = 32'h100;
    upd_valid            = 1'b1;
    upd_pc               = 32'h100;
    upd_flush.address    = 32'h200;
    upd_flush.taken      = 1'b0;
    upd_flush.jump       = 1'b0;
    upd_flush.prediction = 1'b1;
    upd_flush.valid      = 1'b0;
    @(negedge clk);
    clear_inputs();
    chk("rbw.taken", {31'd0, pred_taken}, 32'd1);
    chk("rbw.target", pred_target, 32'h200);
    lookup("rbw_after", 32'h100, 1'b0, 32'h0);
    chk("mispred_6", {16'd0, mispred_cnt}, 32'd6);

    // 5: redirect kills in-flight lookup; upd_valid=0 ignores the rest
    @(negedge clk);
    req_valid       = 1'b1;
    req_pc          = 32'h40;
    upd_pc          = 32'h40;
    upd_flush.valid = 1'b1;
    upd_flush.taken = 1'b0;
    upd_flush.jump  = 1'b0;
    upd_flush.prediction = 1'b1;
    @(negedge clk);
    clear_inputs();
    chk("kill.valid", {31'd0, pred_valid}, 32'd0);
    chk("kill.taken", {31'd0, pred_taken}, 32'd0);
    chk("kill.target", pred_target, 32'd0);
    lookup("no_upd", 32'h40, 1'b1, 32'h80);
    chk("mispred_hold", {16'd0, mispred_cnt}, 32'd6);

    // mispredict counter saturation: 6 + 65528 = 65534, then 65535, then hold
    @(negedge clk);
    upd_valid            = 1'b1;
    upd_pc               = 32'h80;
    upd_flush.taken      = 1'b0;
    upd_flush.prediction = 1'b1;
    repeat (65528) @(negedge clk);
    chk("mispred_fffe", {16'd0, mispred_cnt}, 32'h0000FFFE);
    @(negedge clk);
    chk("mispred_ffff", {16'd0, mispred_cnt}, 32'h0000FFFF);
    repeat (100) @(negedge clk);
    clear_inputs();
    chk("mispred_sat", {16'd0, mispred_cnt}, 32'h0000FFFF);

    // asynchronous reset mid-run discards everything
    lookup("pre_rst", 32'h40, 1'b1, 32'h80);
    @(negedge clk);
    req_valid = 1'b1;
    req_pc    = 32'h40;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.pred_valid", {31'd0, pred_valid}, 32'd0);
    chk("arst.mispred", {16'd0, mispred_cnt}, 32'd0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    lookup("arst_0x100", 32'h100, 1'b0, 32'h0);
    lookup("arst_0x40", 32'h40, 1'b0, 32'h0);

    // 6: alternating T/NT at 0x100, 16 updates starting with T
    for (int k = 0; k < 16; k++) begin
      upd(32'h100, 32'h200, ((k % 2) == 0) ? 1'b1 : 1'b0, 1'b0, 1'b0);
    end
`ifdef BPU_GSHARE_EN
    // history 101010 selects a counter trained to 3 -> taken (pattern: T next)
    lookup("alt_next_t", 32'h100, 1'b1, 32'h200);
    upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b1);
    // history 010101 selects a counter trained to 0 -> not taken
    lookup("alt_next_nt", 32'h100, 1'b0, 32'h0);
`else
    // single counter oscillates 1<->2; ends at 1 so the pattern is missed
    lookup("alt_next_t", 32'h100, 1'b0, 32'h0);
    upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b1);
    lookup("alt_next_nt", 32'h100, 1'b1, 32'h200);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
